// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with a 2-entry skid buffer.
// The main entry drives the WB side. The skid entry absorbs one beat when WB stalls.
// in_ready depends only on registered state and rdy, never on out_ready.
module wb_pipe_reg #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int LANES       = 1,
   parameter bit SUPPRESS_X0 = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic [LANES*ADDR_W-1:0] in_addr,
   input  logic [LANES-1:0]        in_we,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES*ADDR_W-1:0] out_addr,
   output logic [LANES-1:0]        out_we,
   output logic [1:0]              occupancy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic in_fire, out_fire;
   logic load_main_in, load_main_skid, load_skid_in;
   logic [LANES-1:0] cap_we;

   logic [LANES*DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [LANES*ADDR_W-1:0] main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
   logic [LANES-1:0]        main_we_q, main_we_d, skid_we_q, skid_we_d;

   // Write enables as captured: writes to x0 are dropped here so the register file never sees them.
   always_comb begin
      cap_we = in_we;
      if (SUPPRESS_X0) begin
         for (int i = 0; i < LANES; i++) begin
            if (in_addr[i*ADDR_W +: ADDR_W] == '0) cap_we[i] = 1'b0;
         end
      end
   end

   // State register: occupancy of the two-entry buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
   end

   // Next state: flush wins over everything, and rdy=0 freezes the buffer.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else if (rdy) begin
         unique case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_ONE;
            ST_ONE: begin
               if (in_fire && !out_fire)      state_d = ST_TWO;
               else if (!in_fire && out_fire) state_d = ST_EMPTY;
            end
            ST_TWO:   if (out_fire) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   // Outputs and handshakes, plus the load selects for the datapath.
   always_comb begin
      in_ready       = rdy && (state_q != ST_TWO);
      out_valid      = (state_q != ST_EMPTY);
      occupancy      = (state_q == ST_TWO) ? 2'd2 : (state_q == ST_ONE) ? 2'd1 : 2'd0;
      in_fire        = in_valid && in_ready;
      out_fire       = out_valid && out_ready && rdy;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      if (!flush) begin
         unique case (state_q)
            ST_EMPTY: load_main_in = in_fire;
            ST_ONE: begin
               load_main_in = in_fire && out_fire;
               load_skid_in = in_fire && !out_fire;
            end
            ST_TWO:   load_main_skid = out_fire;
            default:  ;
         endcase
      end
   end

   // Next contents of the main and skid entries.
   always_comb begin
      main_data_d = main_data_q;
      main_addr_d = main_addr_q;
      main_we_d   = main_we_q;
      skid_data_d = skid_data_q;
      skid_addr_d = skid_addr_q;
      skid_we_d   = skid_we_q;
      if (load_main_in) begin
         main_data_d = in_data;
         main_addr_d = in_addr;
         main_we_d   = cap_we;
      end else if (load_main_skid) begin
         main_data_d = skid_data_q;
         main_addr_d = skid_addr_q;
         main_we_d   = skid_we_q;
      end
      if (load_skid_in) begin
         skid_data_d = in_data;
         skid_addr_d = in_addr;
         skid_we_d   = cap_we;
      end
   end

   // Entry storage; cleared by reset so the outputs start at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_data_q <= '0;
         main_addr_q <= '0;
         main_we_q   <= '0;
         skid_data_q <= '0;
         skid_addr_q <= '0;
         skid_we_q   <= '0;
      end else begin
         main_data_q <= main_data_d;
         main_addr_q <= main_addr_d;
         main_we_q   <= main_we_d;
         skid_data_q <= skid_data_d;
         skid_addr_q <= skid_addr_d;
         skid_we_q   <= skid_we_d;
      end
   end

   assign out_data = main_data_q;
   assign out_addr = main_addr_q;
   assign out_we   = main_we_q & {LANES{out_valid}};

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg. Two instances share every input: one suppresses x0 writes and one does not.
// The reference model is a FIFO of beats with a capacity of two.
module tb_wb_pipe_reg;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int L  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, rdy, flush, in_valid, out_ready;
   logic [L*DW-1:0] in_data;
   logic [L*AW-1:0] in_addr;
   logic [L-1:0]    in_we;

   logic            in_ready, out_valid, in_ready_b, out_valid_b;
   logic [L*DW-1:0] out_data, out_data_b;
   logic [L*AW-1:0] out_addr, out_addr_b;
   logic [L-1:0]    out_we, out_we_b;
   logic [1:0]      occupancy, occupancy_b;

   wb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .LANES(L), .SUPPRESS_X0(1'b1)) u_dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr), .in_we(in_we),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
      .out_we(out_we), .occupancy(occupancy));

   wb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .LANES(L), .SUPPRESS_X0(1'b0)) u_dut_nx (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_addr(in_addr), .in_we(in_we),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_addr(out_addr_b),
      .out_we(out_we_b), .occupancy(occupancy_b));

   typedef struct {
      logic [L*DW-1:0] d;
      logic [L*AW-1:0] a;
      logic [L-1:0]    we;
      logic [L-1:0]    we_raw;
   } beat_t;

   beat_t q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare both instances against the FIFO model before the next edge.
   task automatic compare_all();
      chk("in_ready", in_ready, rdy && (q.size() < 2));
      chk("out_valid", out_valid, q.size() > 0);
      chk("occupancy", occupancy, q.size());
      chk("in_ready_nx", in_ready_b, rdy && (q.size() < 2));
      chk("occupancy_nx", occupancy_b, q.size());
      if (q.size() > 0) begin
         chk("out_data", out_data, q[0].d);
         chk("out_addr", out_addr, q[0].a);
         chk("out_we", out_we, q[0].we);
         chk("out_data_nx", out_data_b, q[0].d);
         chk("out_we_nx", out_we_b, q[0].we_raw);
      end else begin
         chk("out_we_idle", out_we, 0);
         chk("out_we_idle_nx", out_we_b, 0);
      end
   endtask

   // FIFO semantics at a clock edge.
   task automatic model_edge();
      bit    ir, of, inf;
      beat_t b;
      ir = rdy && (q.size() < 2);
      if (flush) begin
         q.delete();
      end else if (rdy) begin
         of  = (q.size() > 0) && out_ready;
         inf = in_valid && ir;
         if (of) void'(q.pop_front());
         if (inf) begin
            b.d      = in_data;
            b.a      = in_addr;
            b.we_raw = in_we;
            for (int i = 0; i < L; i++)
               b.we[i] = in_we[i] && (in_addr[i*AW +: AW] != 0);
            q.push_back(b);
         end
      end
   endtask

   task automatic cycle();
      #1;
      compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_beat(input logic [DW-1:0] d1, input logic [AW-1:0] a1, input logic w1,
                           input logic [DW-1:0] d0, input logic [AW-1:0] a0, input logic w0);
      in_data = {d1, d0};
      in_addr = {a1, a0};
      in_we   = {w1, w0};
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      set_beat(32'h0, 5'd0, 1'b0, 32'h99, 5'd1, 1'b1);

      // Reset held with a beat on offer
      @(negedge clk); @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_we", out_we, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b1; in_valid = 1'b0;
      #1 chk("rst_in_ready", in_ready, 1);

      // Streaming at one beat per cycle
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         set_beat(32'h0, 5'd0, 1'b0, 32'h11 * (k + 1), 5'(k + 1), 1'b1);
         cycle();
         chk("stream_data", out_data[DW-1:0], 32'h11 * (k + 1));
         chk("stream_occ", occupancy, 1);
      end
      in_valid = 1'b0;
      cycle();
      chk("stream_drained", out_valid, 0);

      // Backpressure fills the skid entry
      out_ready = 1'b0; in_valid = 1'b1;
      set_beat(32'h0, 5'd0, 1'b0, 32'hA, 5'd3, 1'b1); cycle();
      set_beat(32'h0, 5'd0, 1'b0, 32'hB, 5'd4, 1'b1); cycle();
      chk("bp_occ", occupancy, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_head", out_data[DW-1:0], 32'hA);
      set_beat(32'h0, 5'd0, 1'b0, 32'hC, 5'd5, 1'b1); cycle();
      chk("bp_hold", out_data[DW-1:0], 32'hA);
      in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      chk("bp_second", out_data[DW-1:0], 32'hB);
      cycle();
      chk("bp_empty", out_valid, 0);

      // x0 write suppression
      out_ready = 1'b0; in_valid = 1'b1;
      set_beat(32'h1234, 5'd3, 1'b1, 32'hDEAD, 5'd0, 1'b1);
      cycle();
      in_valid = 1'b0;
      chk("x0_valid", out_valid, 1);
      chk("x0_we", out_we, 2'b10);
      chk("x0_we_nx", out_we_b, 2'b11);
      chk("x0_data", out_data[DW-1:0], 32'hDEAD);
      out_ready = 1'b1;
      cycle();

      // Flush with full buffer, then flush racing an accepted beat
      out_ready = 1'b0; in_valid = 1'b1;
      set_beat(32'h0, 5'd0, 1'b0, 32'h51, 5'd1, 1'b1); cycle();
      set_beat(32'h0, 5'd0, 1'b0, 32'h52, 5'd2, 1'b1); cycle();
      flush = 1'b1; cycle();
      flush = 1'b0;
      chk("flush_full_occ", occupancy, 0);
      set_beat(32'h0, 5'd0, 1'b0, 32'h53, 5'd3, 1'b1); cycle();
      set_beat(32'h0, 5'd0, 1'b0, 32'hF1, 5'd4, 1'b1);
      flush = 1'b1; cycle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("flush_occ", occupancy, 0);
      chk("flush_valid", out_valid, 0);
      for (int k = 0; k < 3; k++) cycle();
      chk("flush_never_seen", out_valid, 0);

      // rdy gating with a two-lane beat
      in_valid = 1'b1; out_ready = 1'b0;
      set_beat(32'hCAFE, 5'd7, 1'b1, 32'hBEEF, 5'd2, 1'b1);
      cycle();
      in_valid = 1'b1; out_ready = 1'b1; rdy = 1'b0;
      set_beat(32'h0, 5'd9, 1'b1, 32'h66, 5'd6, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("rdy_hold_data", out_data[DW-1:0], 32'hBEEF);
         chk("rdy_in_ready", in_ready, 0);
      end
      chk("lane1_addr", out_addr[2*AW-1:AW], 5'd7);
      in_valid = 1'b0; rdy = 1'b1;
      cycle();
      chk("rdy_consumed", out_valid, 0);

      // Flush overrides rdy=0
      in_valid = 1'b1; out_ready = 1'b0;
      set_beat(32'h0, 5'd0, 1'b0, 32'h77, 5'd7, 1'b1); cycle();
      in_valid = 1'b0; rdy = 1'b0; flush = 1'b1; cycle();
      rdy = 1'b1; flush = 1'b0;
      chk("flush_rdy0_occ", occupancy, 0);

      // Asynchronous reset mid-operation
      in_valid = 1'b1;
      set_beat(32'h0, 5'd0, 1'b0, 32'h88, 5'd8, 1'b1); cycle();
      set_beat(32'h0, 5'd0, 1'b0, 32'h89, 5'd9, 1'b1); cycle();
      #2 rst = 1'b0;
      #1;
      chk("arst_occ", occupancy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      q.delete();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         rdy       = ($urandom_range(0, 7) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_valid  = $urandom_range(0, 1);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom};
         for (int i = 0; i < L; i++)
            in_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         in_we     = 2'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
